// File: rtl/mips_pkg.sv
// mips_pkg: branch-type encodings, fixed addresses and FSM state type shared by the next-PC logic.
package mips_pkg;
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_J    = 3'd3;
    localparam logic [2:0] BR_JAL  = 3'd4;
    localparam logic [2:0] BR_JR   = 3'd5;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    typedef enum logic {SEQ, DELAY} npc_state_e;
endpackage

// File: rtl/npc_target_calc.sv
// npc_target_calc: combinational branch/jump target, taken decision and JR alignment check for the instruction at pc.
module npc_target_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  br_type,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] pc4,
    output logic [31:0] target,
    output logic        taken,
    output logic        is_branch,
    output logic        misalign
);
    logic        is_jump;
    logic        eq;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    always_comb begin
        pc4       = pc + 32'd4;
        br_tgt    = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
        j_tgt     = {pc4[31:28], instr_index, 2'b00};
        eq        = rs_val == rt_val;
        is_jump   = br_type == BR_J || br_type == BR_JAL || br_type == BR_JR;
        target    = br_type == BR_JR ? rs_val : (br_type == BR_J || br_type == BR_JAL) ? j_tgt : br_tgt;
        taken     = br_type == BR_BEQ ? eq : br_type == BR_BNE ? !eq : is_jump;
        is_branch = br_type == BR_BEQ || br_type == BR_BNE || is_jump;
        misalign  = br_type == BR_JR && |rs_val[1:0];
    end
endmodule

// File: rtl/npc_unit.sv
// npc_unit: next-PC generator with one architectural delay slot, stall hold and exception redirect.
module npc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] EXC_VEC  = mips_pkg::EXC_VEC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] pc,
    input  logic [2:0]  br_type,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        stall,
    input  logic        exc_req,
    output logic [31:0] NPC,
    output logic [31:0] pc_plus8,
    output logic        delay_slot,
    output logic        br_taken,
    output logic        misalign
);
    npc_state_e  state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] pc4, target, npc;
    logic        taken, is_branch, mis_raw, in_seq;

    npc_target_calc u_calc (
        .pc          (pc),
        .br_type     (br_type),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .pc4         (pc4),
        .target      (target),
        .taken       (taken),
        .is_branch   (is_branch),
        .misalign    (mis_raw)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= SEQ;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        npc      = pc4;
        pc_plus8 = pc + 32'd8;
        in_seq   = state_q == SEQ;
        if (exc_req) begin
            npc     = EXC_VEC;
            state_d = SEQ;
        end else if (stall) begin
            npc = pc;
        end else if (!in_seq) begin
            npc     = tgt_q;
            state_d = SEQ;
        end else if (is_branch) begin
            // not-taken branches still resume at pc+8, past the delay slot
            tgt_d   = taken ? target : pc_plus8;
            state_d = DELAY;
        end
        NPC        = Reset ? RESET_PC : npc;
        delay_slot = !Reset && !in_seq;
        br_taken   = !Reset && in_seq && is_branch && taken;
        misalign   = !Reset && in_seq && mis_raw;
    end
endmodule

// File: tb/tb_npc_unit.sv
// tb_npc_unit: table-driven cycle vectors with a scoreboard queue, plus an async-reset-in-delay-slot sequence.
module tb_npc_unit;
    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [2:0]  bt;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        st;
        logic        ex;
        logic [66:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [66:0] exp;
    } sb_t;

    logic        Clk = 0;
    logic        Reset = 1;
    logic [31:0] pc = 0;
    logic [2:0]  br_type = 0;
    logic [15:0] imm16 = 0;
    logic [25:0] instr_index = 0;
    logic [31:0] rs_val = 0;
    logic [31:0] rt_val = 0;
    logic        stall = 0;
    logic        exc_req = 0;
    logic [31:0] NPC;
    logic [31:0] pc_plus8;
    logic        delay_slot;
    logic        br_taken;
    logic        misalign;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    npc_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pc          (pc),
        .br_type     (br_type),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .stall       (stall),
        .exc_req     (exc_req),
        .NPC         (NPC),
        .pc_plus8    (pc_plus8),
        .delay_slot  (delay_slot),
        .br_taken    (br_taken),
        .misalign    (misalign)
    );

    always #5 Clk = ~Clk;

    task automatic add(input logic rst, input logic [31:0] p, input logic [2:0] bt, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] rt, input logic st,
                       input logic ex, input logic [31:0] enpc, input logic [31:0] ep8, input logic eds,
                       input logic etk, input logic emis);
        vec_t v;
        v.rst = rst; v.pc = p; v.bt = bt; v.imm = imm; v.idx = idx;
        v.rs = rs; v.rt = rt; v.st = st; v.ex = ex;
        v.exp = {enpc, ep8, eds, etk, emis};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v, input int id);
        sb_t s;
        Reset = v.rst; pc = v.pc; br_type = v.bt; imm16 = v.imm; instr_index = v.idx;
        rs_val = v.rs; rt_val = v.rt; stall = v.st; exc_req = v.ex;
        s.id = id; s.exp = v.exp;
        sb.push_back(s);
    endtask

    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            sb_t s;
            logic [66:0] act;
            s = sb.pop_front();
            act = {NPC, pc_plus8, delay_slot, br_taken, misalign};
            n_vec++;
            if (act !== s.exp)
                begin
                    n_err++;
                    $display("FAIL vec%0d: got npc=%h p8=%h ds=%b tk=%b mis=%b, want npc=%h p8=%h ds=%b tk=%b mis=%b",
                             s.id, act[66:35], act[34:3], act[2], act[1], act[0],
                             s.exp[66:35], s.exp[34:3], s.exp[2], s.exp[1], s.exp[0]);
                end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        //  rst pc            bt imm       idx         rs            rt    st ex   npc           p8            ds tk mis
        add(1, 32'h0,        0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h3000,     32'h8,        0, 0, 0);
        add(0, 32'h3000,     0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h3004,     32'h3008,     0, 0, 0);
        add(0, 32'h3010,     1, 16'h0003, 26'h0,      32'h5,        32'h5, 0, 0, 32'h3014,     32'h3018,     0, 1, 0);
        add(0, 32'h3014,     0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h3020,     32'h301C,     1, 0, 0);
        add(0, 32'h3020,     2, 16'hFFFF, 26'h0,      32'h7,        32'h7, 0, 0, 32'h3024,     32'h3028,     0, 0, 0);
        add(0, 32'h3024,     0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h3028,     32'h302C,     1, 0, 0);
        add(0, 32'h3000,     4, 16'h0,    26'h0C40,   32'h0,        32'h0, 0, 0, 32'h3004,     32'h3008,     0, 1, 0);
        add(0, 32'h3004,     0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h3100,     32'h300C,     1, 0, 0);
        add(0, 32'h3040,     5, 16'h0,    26'h0,      32'h3003,     32'h0, 0, 0, 32'h3044,     32'h3048,     0, 1, 1);
        add(0, 32'h3044,     0, 16'h0,    26'h0,      32'h0,        32'h0, 1, 0, 32'h3044,     32'h304C,     1, 0, 0);
        add(0, 32'h3044,     0, 16'h0,    26'h0,      32'h0,        32'h0, 1, 0, 32'h3044,     32'h304C,     1, 0, 0);
        add(0, 32'h3044,     0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h3003,     32'h304C,     1, 0, 0);
        add(0, 32'h3000,     3, 16'h0,    26'h0C40,   32'h0,        32'h0, 0, 0, 32'h3004,     32'h3008,     0, 1, 0);
        add(0, 32'h3004,     0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 1, 32'h4180,     32'h300C,     1, 0, 0);
        add(0, 32'h4180,     0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h4184,     32'h4188,     0, 0, 0);
        add(0, 32'h3100,     2, 16'h0004, 26'h0,      32'h1,        32'h2, 1, 0, 32'h3100,     32'h3108,     0, 1, 0);
        add(0, 32'h3100,     2, 16'h0004, 26'h0,      32'h1,        32'h2, 0, 0, 32'h3104,     32'h3108,     0, 1, 0);
        add(0, 32'h3104,     0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h3114,     32'h310C,     1, 0, 0);
        add(0, 32'hFFFFFFFC, 0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h0,        32'h4,        0, 0, 0);
        add(0, 32'hFFFFFFFC, 1, 16'h0001, 26'h0,      32'h0,        32'h0, 0, 0, 32'h0,        32'h4,        0, 1, 0);
        add(0, 32'h0,        0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h4,        32'h8,        1, 0, 0);
        add(0, 32'h90000000, 3, 16'h0,    26'h3FFFFFF, 32'h0,       32'h0, 0, 0, 32'h90000004, 32'h90000008, 0, 1, 0);
        add(0, 32'h90000004, 0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h9FFFFFFC, 32'h9000000C, 1, 0, 0);
        add(0, 32'h3000,     6, 16'h0010, 26'h0,      32'h0,        32'h0, 0, 0, 32'h3004,     32'h3008,     0, 0, 0);
        add(0, 32'h3004,     0, 16'h0,    26'h0,      32'h0,        32'h0, 0, 0, 32'h3008,     32'h300C,     0, 0, 0);
        add(0, 32'h3008,     0, 16'h0,    26'h0,      32'h0,        32'h0, 1, 1, 32'h4180,     32'h3010,     0, 0, 0);
        add(0, 32'h3000,     4, 16'h0,    26'h0C40,   32'h0,        32'h0, 0, 0, 32'h3004,     32'h3008,     0, 1, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge Clk);
            #1;
            drive(vecs[i], i);
        end
        // Short asynchronous reset pulse between edges while a jump target is pending.
        @(posedge Clk);
        #1;
        Reset = 1;
        #2;
        Reset = 0;
        v.rst = 0; v.pc = 32'h3004; v.bt = 0; v.imm = 0; v.idx = 0; v.rs = 0; v.rt = 0; v.st = 0; v.ex = 0;
        v.exp = {32'h3008, 32'h300C, 1'b0, 1'b0, 1'b0};
        drive(v, 100);
        @(posedge Clk);
        #1;
        v.pc = 32'h3008;
        v.exp = {32'h300C, 32'h3010, 1'b0, 1'b0, 1'b0};
        drive(v, 101);
        repeat (3) @(negedge Clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected results never compared, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
